fwd_hazard_unit: RTL and testbench

Parametrised forwarding and interlock unit for the 5-stage pipeline with a non-blocking data cache. It precomputes forwarding selects in ID and registers them into EX. It detects load-use hazards and tracks outstanding cache-miss loads in a per-register scoreboard. It stalls IF/ID, and inserts a bubble into EX, on RAW/WAW conflicts with pending fills or when the miss tracker is full.

---
 rtl/fwd_hazard_unit.sv | 119 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding select precompute, load-use interlock and miss scoreboard for the
// 5-stage pipeline with a non-blocking data cache.
module fwd_hazard_unit #(
  parameter  int AW       = 5,
  parameter  int N_SRC    = 2,
  parameter  int MAX_PEND = 2,
  parameter  int CNT_W    = 16,
  localparam int NREG     = 2 ** AW,
  localparam int PW       = $clog2(MAX_PEND + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [N_SRC*AW-1:0] id_rs,
  input  logic [N_SRC-1:0]    id_src_used,
  input  logic                id_regwrite,
  input  logic [AW-1:0]       id_wr,
  input  logic                id_memread,
  input  logic                ex_valid,
  input  logic                ex_regwrite,
  input  logic                ex_memread,
  input  logic [AW-1:0]       ex_wr,
  input  logic                m_regwrite,
  input  logic [AW-1:0]       m_wr,
  input  logic                miss_valid,
  input  logic [AW-1:0]       miss_wr,
  input  logic                fill_valid,
  input  logic [AW-1:0]       fill_wr,
  output logic                stall_id,
  output logic [N_SRC-1:0]    fwd_en,
  output logic [N_SRC-1:0]    fwd_sel,
  output logic [NREG-1:0]     busy_vec,
  output logic [PW-1:0]       pend_cnt,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic                fill_err
);

  logic [N_SRC-1:0] fwdEn_q, fwdEn_d, fwdSel_q, fwdSel_d;
  logic [NREG-1:0]  busyVec_q, busyVec_d;
  logic [PW-1:0]    pendCnt_q, pendCnt_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic             fillErr_q, fillErr_d;

  logic [N_SRC-1:0] raw, fwdEnNext, fwdSelNext;
  logic             waw, full, missCount, fillHit;

  // EX match beats MEM match: the EX result is the younger value once it reaches MEM.
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    logic [AW-1:0] r;
    logic          u, exHit, mHit;
    assign r     = id_rs[i*AW +: AW];
    assign u     = id_src_used[i] & (r != '0);
    assign exHit = ex_valid & ex_regwrite & (ex_wr == r);
    assign mHit  = m_regwrite & (m_wr == r);
    assign raw[i] = u & ((exHit & ex_memread) | busyVec_q[r] |
                         (miss_valid & (miss_wr == r)));
    assign fwdEnNext[i]  = u & (exHit | mHit);
    assign fwdSelNext[i] = u & ~exHit & mHit;
  end

  assign waw = id_regwrite & (id_wr != '0) &
               (busyVec_q[id_wr] | (miss_valid & (miss_wr == id_wr)));
  assign full     = id_memread & (pendCnt_q == PW'(MAX_PEND));
  assign stall_id = id_valid & ((|raw) | waw | full);

  assign missCount = miss_valid & (miss_wr != '0) & (pendCnt_q != PW'(MAX_PEND));
  assign fillHit   = fill_valid & busyVec_q[fill_wr] & (pendCnt_q != '0);

  // A miss and a fill to the same register in one cycle leave it busy.
  always_comb begin
    busyVec_d = busyVec_q;
    if (fillHit)   busyVec_d[fill_wr] = 1'b0;
    if (missCount) busyVec_d[miss_wr] = 1'b1;

    pendCnt_d = pendCnt_q;
    case ({missCount, fillHit})
      2'b10:   pendCnt_d = pendCnt_q + PW'(1);
      2'b01:   pendCnt_d = pendCnt_q - PW'(1);
      default: pendCnt_d = pendCnt_q;
    endcase

    fillErr_d  = fillErr_q | (fill_valid & ~fillHit);
    stallCnt_d = stallCnt_q;
    if (stall_id && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + CNT_W'(1);

    fwdEn_d  = '0;
    fwdSel_d = '0;
    if (id_valid && !stall_id) begin
      fwdEn_d  = fwdEnNext;
      fwdSel_d = fwdSelNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwdEn_q    <= '0;
      fwdSel_q   <= '0;
      busyVec_q  <= '0;
      pendCnt_q  <= '0;
      stallCnt_q <= '0;
      fillErr_q  <= 1'b0;
    end else begin
      fwdEn_q    <= fwdEn_d;
      fwdSel_q   <= fwdSel_d;
      busyVec_q  <= busyVec_d;
      pendCnt_q  <= pendCnt_d;
      stallCnt_q <= stallCnt_d;
      fillErr_q  <= fillErr_d;
    end
  end

  assign fwd_en    = fwdEn_q;
  assign fwd_sel   = fwdSel_q;
  assign busy_vec  = busyVec_q;
  assign pend_cnt  = pendCnt_q;
  assign stall_cnt = stallCnt_q;
  assign fill_err  = fillErr_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: vector table, directed miss/fill
// sequences and randomized traffic against a behavioural model.
module tb_fwd_hazard_unit;
  localparam int AW = 5, NS = 2, MP = 2, CW = 4, NREG = 32;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_regwrite, id_memread;
  logic [NS*AW-1:0] id_rs;
  logic [NS-1:0] id_src_used;
  logic [AW-1:0] id_wr, ex_wr, m_wr, miss_wr, fill_wr;
  logic ex_valid, ex_regwrite, ex_memread, m_regwrite, miss_valid, fill_valid;
  logic stall_id, fill_err;
  logic [NS-1:0] fwd_en, fwd_sel;
  logic [NREG-1:0] busy_vec;
  logic [1:0] pend_cnt;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // model state
  bit [NREG-1:0] mBusy;
  int mPend;
  bit mErr;
  int mScnt;
  bit [NS-1:0] mEn, mSel;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.AW(AW), .N_SRC(NS), .MAX_PEND(MP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_src_used(id_src_used),
    .id_regwrite(id_regwrite), .id_wr(id_wr), .id_memread(id_memread),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_wr(ex_wr),
    .m_regwrite(m_regwrite), .m_wr(m_wr),
    .miss_valid(miss_valid), .miss_wr(miss_wr),
    .fill_valid(fill_valid), .fill_wr(fill_wr),
    .stall_id(stall_id), .fwd_en(fwd_en), .fwd_sel(fwd_sel),
    .busy_vec(busy_vec), .pend_cnt(pend_cnt), .stall_cnt(stall_cnt), .fill_err(fill_err)
  );

  typedef struct {
    bit idv; bit [9:0] rs; bit [1:0] used;
    bit exv; bit exrw; bit exmr; bit [4:0] exwr;
    bit mrw; bit [4:0] mwr;
    bit stall; bit [1:0] en; bit [1:0] sel;
  } vec_t;

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task clearInputs();
    rst = 1'b0; id_valid = 1'b0; id_rs = '0; id_src_used = '0; id_regwrite = 1'b0;
    id_wr = '0; id_memread = 1'b0; ex_valid = 1'b0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    ex_wr = '0; m_regwrite = 1'b0; m_wr = '0; miss_valid = 1'b0; miss_wr = '0;
    fill_valid = 1'b0; fill_wr = '0;
  endtask

  function automatic bit modelStall();
    bit hit;
    int r;
    bit u;
    hit = 0;
    for (int i = 0; i < NS; i++) begin
      r = int'(id_rs[i*AW +: AW]);
      u = id_src_used[i] && (r != 0);
      if (u && ((ex_valid && ex_memread && ex_regwrite && int'(ex_wr) == r) ||
                mBusy[r] || (miss_valid && int'(miss_wr) == r)))
        hit = 1;
    end
    if (id_regwrite && id_wr != 0 && (mBusy[id_wr] || (miss_valid && miss_wr == id_wr)))
      hit = 1;
    if (id_memread && mPend == MP) hit = 1;
    return id_valid && hit;
  endfunction

  // One clock: check stall before the edge, advance the model, check registers after.
  task applyStimulus(input string tag, output bit stallSeen);
    bit s, missOk, fillOk, u;
    bit [NS-1:0] nEn, nSel;
    int r;
    #2;
    s = modelStall();
    stallSeen = stall_id;
    checkOutput({tag, " stall_id"}, 32'(stall_id), 32'(s));
    nEn = '0; nSel = '0;
    if (id_valid && !s) begin
      for (int i = 0; i < NS; i++) begin
        r = int'(id_rs[i*AW +: AW]);
        u = id_src_used[i] && (r != 0);
        if (u && ex_valid && ex_regwrite && int'(ex_wr) == r) nEn[i] = 1;
        else if (u && m_regwrite && int'(m_wr) == r) begin nEn[i] = 1; nSel[i] = 1; end
      end
    end
    missOk = miss_valid && miss_wr != 0 && mPend < MP;
    fillOk = fill_valid && mBusy[fill_wr] && mPend > 0;
    @(posedge clk);
    #1;
    if (rst) begin
      mBusy = '0; mPend = 0; mErr = 0; mScnt = 0; mEn = '0; mSel = '0;
    end else begin
      mEn = nEn; mSel = nSel;
      if (fill_valid && !fillOk) mErr = 1;
      if (fillOk) mBusy[fill_wr] = 0;
      if (missOk) mBusy[miss_wr] = 1;
      mPend = mPend + int'(missOk) - int'(fillOk);
      if (s && mScnt < CMAX) mScnt++;
    end
    checkOutput({tag, " fwd_en"}, 32'(fwd_en), 32'(mEn));
    checkOutput({tag, " fwd_sel"}, 32'(fwd_sel), 32'(mSel));
    checkOutput({tag, " busy_vec"}, busy_vec, mBusy);
    checkOutput({tag, " pend_cnt"}, 32'(pend_cnt), mPend);
    checkOutput({tag, " stall_cnt"}, 32'(stall_cnt), mScnt);
    checkOutput({tag, " fill_err"}, 32'(fill_err), 32'(mErr));
  endtask

  task doReset();
    bit sd;
    clearInputs();
    rst = 1'b1;
    applyStimulus("reset", sd);
    rst = 1'b0;
  endtask

  initial begin
    vec_t vecs[9];
    bit sd;

    vecs[0] = '{1, {5'd0, 5'd5}, 2'b01, 1, 1, 1, 5'd5, 0, 5'd0, 1, 2'b00, 2'b00};
    vecs[1] = '{1, {5'd0, 5'd5}, 2'b01, 0, 0, 0, 5'd0, 1, 5'd5, 0, 2'b01, 2'b01};
    vecs[2] = '{1, {5'd3, 5'd0}, 2'b10, 1, 1, 0, 5'd3, 1, 5'd3, 0, 2'b10, 2'b00};
    vecs[3] = '{1, {5'd0, 5'd0}, 2'b11, 1, 1, 1, 5'd0, 1, 5'd0, 0, 2'b00, 2'b00};
    vecs[4] = '{0, {5'd0, 5'd3}, 2'b01, 1, 1, 0, 5'd3, 0, 5'd0, 0, 2'b00, 2'b00};
    vecs[5] = '{1, {5'd0, 5'd3}, 2'b00, 1, 1, 1, 5'd3, 0, 5'd0, 0, 2'b00, 2'b00};
    vecs[6] = '{1, {5'd0, 5'd3}, 2'b01, 0, 1, 1, 5'd3, 1, 5'd3, 0, 2'b01, 2'b01};
    vecs[7] = '{1, {5'd6, 5'd4}, 2'b11, 1, 1, 0, 5'd4, 1, 5'd6, 0, 2'b11, 2'b10};
    vecs[8] = '{1, {5'd9, 5'd2}, 2'b11, 1, 1, 1, 5'd9, 1, 5'd2, 1, 2'b00, 2'b00};

    mBusy = '0; mPend = 0; mErr = 0; mScnt = 0; mEn = '0; mSel = '0;
    doReset();
    checkOutput("reset stall_cnt", 32'(stall_cnt), 0);
    checkOutput("reset busy_vec", busy_vec, 0);

    foreach (vecs[k]) begin
      clearInputs();
      id_valid = vecs[k].idv; id_rs = vecs[k].rs; id_src_used = vecs[k].used;
      ex_valid = vecs[k].exv; ex_regwrite = vecs[k].exrw; ex_memread = vecs[k].exmr;
      ex_wr = vecs[k].exwr; m_regwrite = vecs[k].mrw; m_wr = vecs[k].mwr;
      applyStimulus($sformatf("vec%0d", k), sd);
      checkOutput($sformatf("vec%0d table stall", k), 32'(sd), 32'(vecs[k].stall));
      checkOutput($sformatf("vec%0d table fwd_en", k), 32'(fwd_en), 32'(vecs[k].en));
      checkOutput($sformatf("vec%0d table fwd_sel", k), 32'(fwd_sel), 32'(vecs[k].sel));
    end

    // miss to r7 with dependent consumer held until the fill
    doReset();
    id_valid = 1; id_rs = {5'd0, 5'd7}; id_src_used = 2'b01;
    miss_valid = 1; miss_wr = 7;
    applyStimulus("miss r7", sd);
    checkOutput("miss immediate stall", 32'(sd), 1);
    checkOutput("miss busy7", 32'(busy_vec[7]), 1);
    checkOutput("miss pend", 32'(pend_cnt), 1);
    miss_valid = 0;
    for (int c = 0; c < 9; c++) applyStimulus("miss hold", sd);
    fill_valid = 1; fill_wr = 7;
    applyStimulus("fill r7", sd);
    checkOutput("fill-cycle stall", 32'(sd), 1);
    fill_valid = 0;
    checkOutput("release stall", 32'(stall_id), 0);
    checkOutput("release pend", 32'(pend_cnt), 0);
    checkOutput("release stall_cnt", 32'(stall_cnt), 11);

    // WAW and tracker-full interlocks
    doReset();
    miss_valid = 1; miss_wr = 4; applyStimulus("miss r4", sd);
    miss_wr = 6; applyStimulus("miss r6", sd);
    miss_valid = 0;
    checkOutput("two pending", 32'(pend_cnt), 2);
    id_valid = 1; id_regwrite = 1; id_wr = 9; id_memread = 1;
    applyStimulus("full load", sd);
    checkOutput("full stall", 32'(sd), 1);
    id_memread = 0; id_wr = 4;
    applyStimulus("waw add", sd);
    checkOutput("waw stall", 32'(sd), 1);
    id_memread = 1; id_wr = 9; fill_valid = 1; fill_wr = 6;
    applyStimulus("fill r6", sd);
    fill_valid = 0;
    checkOutput("load proceeds", 32'(stall_id), 0);
    checkOutput("pend after fill", 32'(pend_cnt), 1);
    applyStimulus("load go", sd);

    // simultaneous fill+miss, spurious fill, reset with misses outstanding
    clearInputs();
    fill_valid = 1; fill_wr = 4; miss_valid = 1; miss_wr = 4;
    applyStimulus("fill+miss r4", sd);
    checkOutput("set wins busy4", 32'(busy_vec[4]), 1);
    checkOutput("set wins pend", 32'(pend_cnt), 1);
    miss_valid = 0; fill_wr = 12;
    applyStimulus("fill r12", sd);
    checkOutput("fill_err set", 32'(fill_err), 1);
    fill_valid = 0;
    applyStimulus("idle", sd);
    applyStimulus("idle", sd);
    checkOutput("fill_err sticky", 32'(fill_err), 1);
    miss_valid = 1; miss_wr = 5; applyStimulus("miss r5", sd);
    miss_valid = 0;
    checkOutput("pend two before rst", 32'(pend_cnt), 2);
    rst = 1; applyStimulus("mid rst", sd);
    rst = 0;
    checkOutput("rst pend", 32'(pend_cnt), 0);
    checkOutput("rst busy", busy_vec, 0);
    checkOutput("rst fill_err", 32'(fill_err), 0);
    fill_valid = 1; fill_wr = 4; applyStimulus("late fill", sd);
    fill_valid = 0;
    checkOutput("late fill err", 32'(fill_err), 1);
    checkOutput("late fill pend", 32'(pend_cnt), 0);

    // randomized traffic
    doReset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(99) == 0);
      id_valid = $urandom_range(3) != 0;
      id_rs = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
      id_src_used = 2'($urandom_range(0, 3));
      id_regwrite = $urandom_range(1);
      id_wr = 5'($urandom_range(0, 9));
      id_memread = $urandom_range(2) == 0;
      ex_valid = $urandom_range(1);
      ex_regwrite = $urandom_range(1);
      ex_memread = $urandom_range(1);
      ex_wr = 5'($urandom_range(0, 9));
      m_regwrite = $urandom_range(1);
      m_wr = 5'($urandom_range(0, 9));
      miss_valid = $urandom_range(3) == 0;
      miss_wr = 5'($urandom_range(0, 9));
      fill_valid = $urandom_range(3) == 0;
      fill_wr = 5'($urandom_range(0, 9));
      applyStimulus("rand", sd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
